// File: rtl/bldc_pkg.sv
// -----------------------------------------------------------------------------
// bldc_pkg
// Shared types and constants for the open-loop BLDC ramp controller:
//   - phase_t       : 3-bit commutation phase (PH_IDLE, P_1..P_6)
//   - ctrl_state_t  : sequencer state (IDLE, ALIGN, RAMP, RUN)
//   - PAT_P1..P6    : 6-bit gate status patterns {AH,AL,BH,BL,CH,CL}
//   - phase_status(): phase -> gate status decode (PH_IDLE decodes to all-off)
// -----------------------------------------------------------------------------
package bldc_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    P_1     = 3'd1,
    P_2     = 3'd2,
    P_3     = 3'd3,
    P_4     = 3'd4,
    P_5     = 3'd5,
    P_6     = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RAMP  = 2'd2,
    ST_RUN   = 2'd3
  } ctrl_state_t;

  localparam logic [5:0] PAT_P1 = 6'b100100;
  localparam logic [5:0] PAT_P2 = 6'b100001;
  localparam logic [5:0] PAT_P3 = 6'b001001;
  localparam logic [5:0] PAT_P4 = 6'b011000;
  localparam logic [5:0] PAT_P5 = 6'b010010;
  localparam logic [5:0] PAT_P6 = 6'b000110;

  function automatic logic [5:0] phase_status(input phase_t ph);
    logic [5:0] pat;
    pat = 6'b000000;
    case (ph)
      P_1:     pat = PAT_P1;
      P_2:     pat = PAT_P2;
      P_3:     pat = PAT_P3;
      P_4:     pat = PAT_P4;
      P_5:     pat = PAT_P5;
      P_6:     pat = PAT_P6;
      default: pat = 6'b000000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bldc_period_slew.sv
// -----------------------------------------------------------------------------
// bldc_period_slew
// Combinational slew of the commutation period toward a clamped target.
//   cur_i            : current period
//   target_i         : requested target period (floored at MIN_PERIOD here)
//   step_i           : max change per commutation (0 behaves as 1)
//   next_o           : cur_i moved toward the clamped target, never overshooting
//   target_clamped_o : max(target_i, MIN_PERIOD)
// -----------------------------------------------------------------------------
module bldc_period_slew #(
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 16
) (
  input  logic [PERIOD_W-1:0] cur_i,
  input  logic [PERIOD_W-1:0] target_i,
  input  logic [PERIOD_W-1:0] step_i,
  output logic [PERIOD_W-1:0] next_o,
  output logic [PERIOD_W-1:0] target_clamped_o
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  logic [PERIOD_W-1:0] tgt;
  logic [PERIOD_W-1:0] step_eff;
  logic [PERIOD_W-1:0] diff;
  logic [PERIOD_W-1:0] delta;

  always_comb begin
    tgt      = (target_i < MIN_P) ? MIN_P : target_i;
    step_eff = (step_i == '0) ? PERIOD_W'(1) : step_i;
    // Distance is computed in the direction of travel so it never wraps.
    diff     = (cur_i < tgt) ? (tgt - cur_i) : (cur_i - tgt);
    delta    = (diff < step_eff) ? diff : step_eff;
    next_o   = (cur_i < tgt) ? (cur_i + delta) : (cur_i - delta);
    target_clamped_o = tgt;
  end

endmodule

// File: rtl/bldc_ol_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// bldc_ol_ramp_ctrl
// Open-loop BLDC start-up / speed scheduler. Holds phase 1 for ALIGN_CYCLES,
// then steps the 6-step commutation with a period slewed from the start period
// toward the (floored) target period.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   ena_i            : 1 = run, 0 = stop (to IDLE next cycle, outputs 0)
//   start_period_i   : period after alignment, sampled on IDLE->ALIGN
//   target_period_i  : desired period, sampled at each commutation
//   ramp_step_i      : max period change per commutation (0 behaves as 1)
//   phase_o          : 0 idle, 1..6 commutation phase
//   status_o         : gate pattern {AH,AL,BH,BL,CH,CL}
//   comm_tick_o      : 1-cycle pulse when phase_o takes a new 1..6 value
//   at_speed_o       : 1 in RUN (current period equals clamped target)
// Build option: BLDC_DEADTIME_EN blanks status_o for DEADTIME_CYCLES cycles
// starting with every comm_tick_o cycle and with the IDLE->ALIGN entry.
// -----------------------------------------------------------------------------
module bldc_ol_ramp_ctrl
  import bldc_pkg::*;
#(
  parameter int PERIOD_W        = 16,
  parameter int MIN_PERIOD      = 16,
  parameter int ALIGN_CYCLES    = 1000,
  parameter int DEADTIME_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ena_i,
  input  logic [PERIOD_W-1:0] start_period_i,
  input  logic [PERIOD_W-1:0] target_period_i,
  input  logic [PERIOD_W-1:0] ramp_step_i,
  output logic [2:0]          phase_o,
  output logic [5:0]          status_o,
  output logic                comm_tick_o,
  output logic                at_speed_o
);

  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ALIGN_LAST = PERIOD_W'(ALIGN_CYCLES - 1);

  if (ALIGN_CYCLES < 1) begin : g_bad_align
    $error("ALIGN_CYCLES must be at least 1");
  end
  if (DEADTIME_CYCLES < 1 || DEADTIME_CYCLES >= MIN_PERIOD) begin : g_bad_dt
    $error("DEADTIME_CYCLES must be in 1..MIN_PERIOD-1");
  end

  ctrl_state_t         state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [5:0]          status_q, status_d;
  logic                tick_q, tick_d;
  logic                at_speed_q, at_speed_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cur_q, cur_d;

  logic [PERIOD_W-1:0] slew_next;
  logic [PERIOD_W-1:0] tgt_clamped;
  logic [PERIOD_W-1:0] start_clamped;

  bldc_period_slew #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_slew (
    .cur_i            (cur_q),
    .target_i         (target_period_i),
    .step_i           (ramp_step_i),
    .next_o           (slew_next),
    .target_clamped_o (tgt_clamped)
  );

  assign start_clamped = (start_period_i < MIN_P) ? MIN_P : start_period_i;

`ifdef BLDC_DEADTIME_EN
  logic [PERIOD_W-1:0] dt_q, dt_d;
  logic                blank;
`endif

  // Sequencer: next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    at_speed_d = at_speed_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;

    if (!ena_i) begin
      // Stop wins over any commutation due in this cycle.
      state_d    = ST_IDLE;
      phase_d    = PH_IDLE;
      at_speed_d = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ALIGN;
          phase_d    = P_1;
          at_speed_d = 1'b0;
          cnt_d      = '0;
          cur_d      = start_clamped;
        end
        ST_ALIGN: begin
          if (cnt_q == ALIGN_LAST) begin
            state_d = ST_RAMP;
            phase_d = P_2;
            tick_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        ST_RAMP, ST_RUN: begin
          if (cnt_q == cur_q - PERIOD_W'(1)) begin
            phase_d = (phase_q == P_6) ? P_1 : phase_t'(phase_q + 3'd1);
            tick_d  = 1'b1;
            cnt_d   = '0;
            cur_d   = slew_next;
            // RUN/RAMP decided on the updated period.
            if (slew_next == tgt_clamped) begin
              state_d    = ST_RUN;
              at_speed_d = 1'b1;
            end else begin
              state_d    = ST_RAMP;
              at_speed_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          phase_d    = PH_IDLE;
          at_speed_d = 1'b0;
          cnt_d      = '0;
        end
      endcase
    end

`ifdef BLDC_DEADTIME_EN
    // Blank window starts in the tick cycle (or alignment entry) and covers
    // DEADTIME_CYCLES cycles of status_o in total.
    blank = tick_d || (state_q == ST_IDLE && state_d == ST_ALIGN);
    if (!ena_i) begin
      dt_d = '0;
    end else if (blank) begin
      dt_d = PERIOD_W'(DEADTIME_CYCLES - 1);
    end else if (dt_q != '0) begin
      dt_d = dt_q - PERIOD_W'(1);
    end else begin
      dt_d = '0;
    end
    status_d = (blank || dt_q != '0) ? 6'b000000 : phase_status(phase_d);
`else
    status_d = phase_status(phase_d);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_IDLE;
      status_q   <= 6'b000000;
      tick_q     <= 1'b0;
      at_speed_q <= 1'b0;
      cnt_q      <= '0;
      cur_q      <= MIN_P;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      status_q   <= status_d;
      tick_q     <= tick_d;
      at_speed_q <= at_speed_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
    end
  end

`ifdef BLDC_DEADTIME_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dt_q <= '0;
    end else begin
      dt_q <= dt_d;
    end
  end
`endif

  assign phase_o     = phase_q;
  assign status_o    = status_q;
  assign comm_tick_o = tick_q;
  assign at_speed_o  = at_speed_q;

endmodule
